// File: rtl/cpu_pkg.sv
// cpu_pkg: function codes, opcodes, sequencer states and decoded-control bundle
package cpu_pkg;
    localparam logic [2:0] REG_HOLD  = 3'd0;
    localparam logic [2:0] REG_LOAD  = 3'd1;
    localparam logic [2:0] REG_CLEAR = 3'd2;
    localparam logic [2:0] REG_SHR   = 3'd3;
    localparam logic [2:0] REG_SHL   = 3'd4;
    localparam logic [2:0] ULA_ADD   = 3'd0;
    localparam logic [2:0] ULA_SUB   = 3'd1;
    localparam logic [2:0] ULA_AND   = 3'd2;
    localparam logic [2:0] ULA_OR    = 3'd3;
    localparam logic [2:0] ULA_XOR   = 3'd4;
    localparam logic [2:0] ULA_NOT   = 3'd5;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDX = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_MVZ = 4'h8;
    localparam logic [3:0] OP_CLR = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_SHL = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC1, S_EXEC2, S_HALT} state_t;
    typedef struct packed {
        logic [2:0] tx;
        logic [2:0] ty;
        logic [2:0] tz;
        logic [2:0] tula;
        logic       two_cycle;
        logic       is_jmp;
        logic       is_hlt;
    } dec_t;
endpackage

// File: rtl/op_decoder.sv
// op_decoder: combinational opcode -> first-execute-cycle function codes and flow flags
import cpu_pkg::*;

module op_decoder (
    input  logic [3:0] ir,
    output dec_t       dec
);
    always_comb begin
        dec           = '0;
        dec.two_cycle = ir inside {[OP_ADD:OP_NOT]};
        // ALU opcodes are contiguous, so the ULA code is an offset from ADD
        dec.tula      = dec.two_cycle ? 3'(ir - OP_ADD) : ULA_ADD;
        dec.tx        = ir == OP_LDX ? REG_LOAD : ir == OP_CLR ? REG_CLEAR : REG_HOLD;
        dec.ty        = ir == OP_CLR ? REG_CLEAR : ir == OP_SHR ? REG_SHR :
                        ir == OP_SHL ? REG_SHL : REG_HOLD;
        dec.tz        = ir == OP_MVZ ? REG_LOAD : ir == OP_CLR ? REG_CLEAR : REG_HOLD;
        dec.is_jmp    = ir == OP_JMP;
        dec.is_hlt    = ir == OP_HLT;
    end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/execute control FSM owning the program counter.
// Optional STEP_MODE_EN adds a step input that gates each FETCH.
import cpu_pkg::*;

module instr_sequencer #(
    parameter int ADDR_W   = 4,
    parameter int PROG_LEN = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
`ifdef STEP_MODE_EN
    input  logic              step,
`endif
    input  logic [3:0]        instr,
    input  logic [3:0]        data,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        Tx,
    output logic [2:0]        Ty,
    output logic [2:0]        Tz,
    output logic [2:0]        Tula,
    output logic              busy,
    output logic              done,
    output logic              halted
);
    state_t            state, nxt;
    logic [3:0]        ir, dr;
    logic [ADDR_W-1:0] pc_nxt, pc_inc, pc_jmp;
    logic              go;
    dec_t              dec;

    op_decoder u_dec (.ir(ir), .dec(dec));

`ifdef STEP_MODE_EN
    assign go = step;
`else
    assign go = 1'b1;
`endif

    assign pc_inc = pc == ADDR_W'(PROG_LEN - 1) ? '0 : pc + 1'b1;
    assign pc_jmp = 32'(dr) >= PROG_LEN ? '0 : ADDR_W'(dr);

    always_comb begin
        nxt    = state;
        pc_nxt = pc;
        case (state)
            S_IDLE, S_HALT: begin
                nxt    = start ? S_FETCH : state;
                pc_nxt = start ? '0 : pc;
            end
            S_FETCH: nxt = go ? S_EXEC1 : S_FETCH;
            S_EXEC1: begin
                nxt    = dec.is_hlt ? S_HALT : dec.two_cycle ? S_EXEC2 : S_FETCH;
                pc_nxt = dec.is_hlt || dec.two_cycle ? pc : dec.is_jmp ? pc_jmp : pc_inc;
            end
            S_EXEC2: begin
                nxt    = S_FETCH;
                pc_nxt = pc_inc;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            dr    <= '0;
        end else begin
            state <= nxt;
            pc    <= pc_nxt;
            if (state == S_FETCH && go) begin
                ir <= instr;
                dr <= data;
            end
        end
    end

    // ALU ops write Y only in EXEC2, after the ULA result has settled for a cycle
    always_comb begin
        Tx     = state == S_EXEC1 ? dec.tx : REG_HOLD;
        Ty     = state == S_EXEC1 ? dec.ty : state == S_EXEC2 ? REG_LOAD : REG_HOLD;
        Tz     = state == S_EXEC1 ? dec.tz : REG_HOLD;
        Tula   = state == S_EXEC1 || state == S_EXEC2 ? dec.tula : ULA_ADD;
        busy   = state == S_FETCH || state == S_EXEC1 || state == S_EXEC2;
        halted = state == S_HALT;
        done   = state == S_EXEC1 && dec.is_hlt;
    end
endmodule
